// File: rtl/referee_pop.sv
// Round-robin pop referee: drains POP_FIFO source FIFOs into one destination FIFO
// in bursts of up to BURST_MAX words, throttled by source and destination flags.
module referee_pop #(
  parameter int unsigned POP_FIFO   = 4,
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [POP_FIFO-1:0]            empty_monarchy,
  input  logic [POP_FIFO-1:0]            almost_empty_monarchy,
  input  logic [POP_FIFO*DATA_WIDTH-1:0] data_in_monarchy,
  input  logic                           almost_full_monarchy,
  output logic [POP_FIFO-1:0]            pop_monarchy,
  output logic                           push_monarchy,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [$clog2(POP_FIFO)-1:0]    grant
);

  localparam int unsigned GW = $clog2(POP_FIFO);
  localparam int unsigned BW = $clog2(BURST_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic                  rd_valid_q;
  logic [GW-1:0]         rd_idx_q;
  logic                  push_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  pop_fire_c;
  logic                  scan_found;
  logic [GW-1:0]         scan_cand;
  logic [DATA_WIDTH-1:0] src_data [POP_FIFO];

  for (genvar g = 0; g < POP_FIFO; g++) begin : g_slice
    assign src_data[g] = data_in_monarchy[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // A pop happens only while serving a non-empty source with room downstream.
  assign pop_fire_c = (state_q == SERVE) && !empty_monarchy[grant_q] && !almost_full_monarchy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= GW'(POP_FIFO - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    burst_d    = burst_q;
    scan_found = 1'b0;
    scan_cand  = '0;
    case (state_q)
      IDLE: begin
        // Scan starts one past the last served source so every source gets a turn.
        for (int unsigned k = 1; k <= POP_FIFO; k++) begin
          scan_cand = GW'((32'(grant_q) + k) % POP_FIFO);
          if (!scan_found && !empty_monarchy[scan_cand]) begin
            scan_found = 1'b1;
            grant_d    = scan_cand;
          end
        end
        if (scan_found) begin
          state_d = SERVE;
          burst_d = '0;
        end
      end
      SERVE: begin
        if (empty_monarchy[grant_q]) begin
          state_d = IDLE;
        end else if (!almost_full_monarchy) begin
          burst_d = burst_q + BW'(1);
          if (almost_empty_monarchy[grant_q] || (burst_q == BW'(BURST_MAX - 1))) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop_monarchy = '0;
    if (pop_fire_c) begin
      pop_monarchy[grant_q] = 1'b1;
    end
  end

  // Read data arrives the cycle after the pop; it is registered out one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      push_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      rd_valid_q <= pop_fire_c;
      if (pop_fire_c) begin
        rd_idx_q <= grant_q;
      end
      push_q <= rd_valid_q;
      if (rd_valid_q) begin
        data_q <= src_data[rd_idx_q];
      end
    end
  end

  assign push_monarchy = push_q;
  assign data_out      = data_q;
  assign grant         = grant_q;

endmodule

// File: tb/tb_referee_pop.sv
// Bench for referee_pop: source FIFOs modelled as queues, a transaction-level
// arbitration model predicts pops, pushes, data and grant every cycle.
module tb_referee_pop;

  localparam int unsigned NF = 4;
  localparam int unsigned DW = 10;
  localparam int unsigned BM = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NF-1:0]     empty_monarchy;
  logic [NF-1:0]     almost_empty_monarchy;
  logic [NF*DW-1:0]  data_in_monarchy;
  logic              almost_full_monarchy;
  logic [NF-1:0]     pop_monarchy;
  logic              push_monarchy;
  logic [DW-1:0]     data_out;
  logic [1:0]        grant;

  referee_pop #(.POP_FIFO(NF), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .empty_monarchy        (empty_monarchy),
    .almost_empty_monarchy (almost_empty_monarchy),
    .data_in_monarchy      (data_in_monarchy),
    .almost_full_monarchy  (almost_full_monarchy),
    .pop_monarchy          (pop_monarchy),
    .push_monarchy         (push_monarchy),
    .data_out              (data_out),
    .grant                 (grant)
  );

  always #5 clk = ~clk;

  // Source FIFOs: contents, and the read register that shows the popped word.
  logic [DW-1:0] srcq [NF][$];
  logic [DW-1:0] data_reg [NF];

  always_comb begin
    for (int i = 0; i < NF; i++) data_in_monarchy[i*DW +: DW] = data_reg[i];
  end

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit            m_rst;
  bit            m_serv;
  int            m_cur;
  int            m_cnt;
  bit            s1_v;
  logic [DW-1:0] s1_d;
  bit            o_v;
  logic [DW-1:0] o_d;

  // Observations of the DUT.
  int            cyc = 0;
  int            obs_pops [NF];
  int            obs_src [$];
  int            obs_cyc [$];
  logic [DW-1:0] obs_push_d [$];

  function automatic void upd_flags();
    for (int i = 0; i < NF; i++) begin
      empty_monarchy[i]        = (srcq[i].size() == 0);
      almost_empty_monarchy[i] = (srcq[i].size() <= 1);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_serv = 1'b0;
    m_cur  = NF - 1;
    m_cnt  = 0;
    s1_v   = 1'b0;
    o_v    = 1'b0;
    o_d    = '0;
  endtask

  task automatic step(input bit af, input bit drop_rst);
    logic [NF-1:0] ep;
    logic [DW-1:0] w;
    int            pi;
    bit            found;
    @(negedge clk);
    almost_full_monarchy = af;
    #1;
    ep = '0;
    w  = '0;
    pi = -1;
    if (!m_rst && m_serv && srcq[m_cur].size() > 0 && !af) begin
      pi     = m_cur;
      ep[pi] = 1'b1;
      w      = srcq[pi][0];
    end
    chk("pop", 32'(pop_monarchy), 32'(ep));
    chk("push", 32'(push_monarchy), 32'(o_v));
    chk("data", 32'(data_out), 32'(o_d));
    chk("grant", 32'(grant), 32'(m_cur));
    for (int i = 0; i < NF; i++) begin
      if (pop_monarchy[i] === 1'b1) begin
        obs_pops[i]++;
        obs_src.push_back(i);
        obs_cyc.push_back(cyc);
      end
    end
    if (push_monarchy === 1'b1) obs_push_d.push_back(data_out);
    if (drop_rst) begin
      reset = 1'b0;
      #1;
      m_rst = 1'b1;
      model_reset();
      chk("rst_pop", 32'(pop_monarchy), 32'd0);
      chk("rst_push", 32'(push_monarchy), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_grant", 32'(grant), 32'(NF - 1));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!m_rst) begin
      o_v = s1_v;
      if (s1_v) o_d = s1_d;
      s1_v = (pi >= 0);
      s1_d = w;
      if (!m_serv) begin
        found = 1'b0;
        for (int k = 1; k <= NF; k++) begin
          int j;
          j = (m_cur + k) % NF;
          if (!found && srcq[j].size() > 0) begin
            found  = 1'b1;
            m_serv = 1'b1;
            m_cur  = j;
            m_cnt  = 0;
          end
        end
      end else if (srcq[m_cur].size() == 0) begin
        m_serv = 1'b0;
      end else if (!af) begin
        m_cnt++;
        if (srcq[m_cur].size() <= 1 || m_cnt == BM) m_serv = 1'b0;
      end
      if (pi >= 0) data_reg[pi] = srcq[pi].pop_front();
    end
    upd_flags();
  endtask

  task automatic load(input int s, input int n, input int base);
    for (int k = 0; k < n; k++) srcq[s].push_back(DW'(base + k));
    upd_flags();
  endtask

  initial begin
    int b, p0, n, pu;
    reset = 1'b1;
    almost_full_monarchy = 1'b0;
    for (int i = 0; i < NF; i++) begin
      data_reg[i] = '0;
      obs_pops[i] = 0;
    end
    upd_flags();
    m_rst = 1'b1;
    model_reset();
    #2 reset = 1'b0;

    // Reset held with every source full of words; fairness run follows.
    for (int i = 0; i < NF; i++) load(i, 8, (i << 6) | 8'h20);
    for (int i = 0; i < 3; i++) step(0, 0);
    reset = 1'b1;
    m_rst = 1'b0;
    for (int i = 0; i < 50; i++) step(0, 0);
    chk("fair_npops", 32'(obs_src.size()), 32'd32);
    for (int i = 0; i < 20 && i < obs_src.size(); i++) begin
      chk("fair_src", 32'(obs_src[i]), 32'((i / 4) % NF));
      if (i > 0) chk("fair_gap", 32'(obs_cyc[i] - obs_cyc[i-1]), (i % 4 == 0) ? 32'd2 : 32'd1);
    end

    // Single source with three words.
    b = obs_src.size();
    p0 = obs_push_d.size();
    srcq[1].push_back(10'h011);
    srcq[1].push_back(10'h012);
    srcq[1].push_back(10'h013);
    upd_flags();
    for (int i = 0; i < 10; i++) step(0, 0);
    chk("single_npops", 32'(obs_src.size() - b), 32'd3);
    for (int i = b; i < obs_src.size(); i++) chk("single_src", 32'(obs_src[i]), 32'd1);
    if (obs_src.size() == b + 3) chk("single_run", 32'(obs_cyc[b+2] - obs_cyc[b]), 32'd2);
    chk("single_npush", 32'(obs_push_d.size() - p0), 32'd3);
    for (int i = 0; i < 3 && p0 + i < obs_push_d.size(); i++)
      chk("single_word", 32'(obs_push_d[p0+i]), 32'h011 + 32'(i));

    // Back-pressure after the second pop of a burst.
    load(0, 8, 10'h100);
    b = obs_pops[0];
    for (int i = 0; i < 20 && obs_pops[0] - b < 2; i++) step(0, 0);
    chk("bp_reach", 32'(obs_pops[0] - b), 32'd2);
    p0 = obs_push_d.size();
    b = obs_pops[0];
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("bp_pushes", 32'(obs_push_d.size() - p0), 32'd2);
    chk("bp_nopop", 32'(obs_pops[0] - b), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("bp_resume", 32'(obs_pops[0] - b), 32'd2);
    for (int i = 0; i < 15; i++) step(0, 0);

    // Sparse: a single word in source 2.
    for (int i = 0; i < NF; i++) b = 0;
    n = obs_pops[0] + obs_pops[1] + obs_pops[3];
    b = obs_pops[2];
    load(2, 1, 10'h2AA);
    for (int i = 0; i < 10; i++) step(0, 0);
    chk("sparse_pop2", 32'(obs_pops[2] - b), 32'd1);
    chk("sparse_other", 32'(obs_pops[0] + obs_pops[1] + obs_pops[3] - n), 32'd0);

    // Asynchronous reset in the middle of a source 0 burst.
    for (int i = 0; i < 6; i++) step(0, 0);
    load(0, 6, 10'h180);
    b = obs_pops[0];
    for (int i = 0; i < 20 && obs_pops[0] - b < 2; i++) step(0, 0);
    chk("rst_reach", 32'(obs_pops[0] - b), 32'd2);
    pu = obs_push_d.size();
    step(0, 1);
    step(0, 0);
    step(0, 0);
    chk("rst_quiet", 32'(obs_push_d.size() - pu), 32'd1);
    reset = 1'b1;
    m_rst = 1'b0;
    for (int i = 0; i < 30; i++) step(0, 0);

    // Random traffic and back-pressure.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        n = int'($urandom_range(1, 5));
        load(int'($urandom_range(0, NF - 1)), n, int'($urandom_range(0, 1023)));
      end
      step($urandom_range(0, 3) == 0, 0);
    end
    for (int i = 0; i < 80; i++) step(0, 0);
    for (int i = 0; i < NF; i++) chk("drained", 32'(empty_monarchy[i]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/referee_pop.md
# referee_pop

Round-robin pop referee for the transaction layer: drains POP_FIFO source FIFOs (one per virtual channel) into a single destination FIFO. It is the read-side counterpart of the push referee. It issues pop strobes to the source FIFOs, steers the returned word to the destination and issues its push. Arbitration is burst-based round-robin, throttled by destination almost_full and source empty/almost_empty flags.

## Interface
- POP_FIFO, 4, number of source FIFOs arbitrated (≥2)
- DATA_WIDTH, 10, width of one FIFO word
- BURST_MAX, 4, maximum consecutive pops granted to one source (≥1)
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- empty_monarchy  input  POP_FIFO  source FIFO empty flags
- almost_empty_monarchy  input  POP_FIFO  source holds ≤1 word
- data_in_monarchy  input  POP_FIFO*DATA_WIDTH  source read data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]; valid the cycle after pop
- almost_full_monarchy  input  1  destination FIFO almost full
- pop_monarchy  output  POP_FIFO  one-hot pop strobe to sources (at most one bit high)
- push_monarchy  output  1  push strobe to destination, registered
- data_out  output  DATA_WIDTH  word to destination, registered, valid when push_monarchy=1
- grant  output  clog2(POP_FIFO)  index of currently/last served source, registered

## Operation
- States: IDLE, SERVE. Registers: state, grant, burst_cnt, rd_valid_q, rd_idx_q, push_monarchy, data_out.
- IDLE: scan sources (grant+1) mod POP_FIFO, (grant+2) …, wrapping, for first with empty=0. If found: grant<=index, burst_cnt<=0, go SERVE. If none: stay IDLE. No pop in IDLE.
- SERVE: pop_monarchy[grant]=1 (combinational from registered state/grant and current flags) iff empty[grant]=0 and almost_full_monarchy=0.
- On a pop: burst_cnt<=burst_cnt+1. Burst ends (next state IDLE) if almost_empty[grant]=1 in the pop cycle, or burst_cnt==BURST_MAX-1.
- SERVE with empty[grant]=1: go IDLE, no pop.
- SERVE with almost_full=1 and empty[grant]=0: pop held low; stay SERVE, burst_cnt held.
- Source flags update the cycle after a pop. Stopping after an almost_empty pop guarantees no pop of an empty FIFO.
- Read pipeline: pop cycle N sets rd_valid_q<=1, rd_idx_q<=grant. At N+1, if rd_valid_q: data_out<=slice rd_idx_q of data_in, push_monarchy<=1; else push_monarchy<=0, data_out holds.
- Ordering: words pushed in exact pop order. No word dropped or duplicated except on reset.

## Timing
- Reset values (reset=0, asynchronous): state=IDLE, grant=POP_FIFO-1 (so first scan starts at 0), burst_cnt=0, rd_valid_q=0, push_monarchy=0, data_out=0.
- pop_monarchy=0 whenever reset=0, since it is decoded from state=IDLE.
- Latency: pop at cycle N, push_monarchy/data_out at N+2. Throughput is 1 word/cycle within a burst.
- Burst switch: one IDLE cycle between bursts, so the last pop of one burst and the first pop of the next are 2 cycles apart.
- Back-pressure: after almost_full rises, at most 2 further pushes occur (words popped at N-1 and N). The destination almost_full threshold must leave ≥2 free entries.
- almost_full toggling mid-burst: pop follows it combinationally in the same cycle. Burst resumes with preserved burst_cnt.
- Simultaneous almost_empty and burst_cnt==BURST_MAX-1: one pop, then IDLE (same result).
- Reset mid-burst: in-flight words (rd_valid_q, pending push) are discarded. The first cycle after release behaves as post-reset IDLE.

## Test plan
- Reset: hold reset=0 for 3 cycles with sources non-empty -> pop=0, push=0, data_out=0, grant=3. First grant after release is source 0.
- Single source: source 1 holds 0x011,0x012,0x013 (almost_empty high on last), BURST_MAX=4 -> pop[1] high 3 consecutive cycles, then IDLE. push high 2 cycles after each pop with data_out 0x011,0x012,0x013 in order.
- Fairness: all 4 sources hold ≥8 words -> grant sequence 0,1,2,3,0. Each burst is exactly 4 pops, with one idle cycle between bursts.
- Back-pressure: almost_full rises after 2nd pop of a burst -> pop drops the same cycle, exactly 2 more pushes, none after. On release, the remaining 2 pops of the burst complete.
- Sparse/empty: only source 2 non-empty, holding 1 word (almost_empty=1) -> exactly one pop[2], no pop while empty, referee idles scanning. Sources 0,1,3 never popped.
- Async reset mid-burst: drop reset between clock edges during source 0 burst -> pop/push go 0 immediately. The pending word is never pushed.
